// File: rtl/psum_accum_pkg.sv
// psum_accum_ctrl shared types and arithmetic helpers.
// ACCUM_SAT_EN: saturating accumulate instead of wrapping.
package psum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int psum_width(input int dw);
    return 2 * dw;
  endfunction

`ifdef ACCUM_SAT_EN
  // {positive overflow, negative overflow} from operand/result signs
  function automatic logic [1:0] sat_sel(
    input logic a_s,
    input logic b_s,
    input logic r_s
  );
    return {~a_s & ~b_s & r_s, a_s & b_s & ~r_s};
  endfunction
`endif

endpackage

// File: rtl/psum_accum_ctrl_if.sv
// Pass control, psum stream and row-read bundle for psum_accum_ctrl.
// master drives pass/psum/read requests; slave is the controller.
interface psum_accum_ctrl_if
  import psum_accum_pkg::*;
#(
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024
);
  localparam int PW = psum_width(DATA_WIDTH);
  localparam int AW = $clog2(ACCUM_SIZE);

  logic                         start;
  logic [DATA_WIDTH-1:0]        num_row;
  logic [AW-1:0]                base_addr;
  logic                         acc_mode;
  logic [SYS_COL-1:0][PW-1:0]   psum_in;
  logic [SYS_COL-1:0]           en_in;
  logic                         busy;
  logic                         done;
  logic                         ovf_err;
  logic                         rd_en;
  logic [AW-1:0]                rd_addr;
  logic [SYS_COL-1:0][PW-1:0]   rd_data;

  modport master (
    output start, num_row, base_addr, acc_mode,
    output psum_in, en_in, rd_en, rd_addr,
    input  busy, done, ovf_err, rd_data
  );

  modport slave (
    input  start, num_row, base_addr, acc_mode,
    input  psum_in, en_in, rd_en, rd_addr,
    output busy, done, ovf_err, rd_data
  );

endinterface

// File: rtl/psum_accum_ctrl_accum_bank.sv
// One column's accumulator storage with RMW write and registered read.
// ACCUM_SAT_EN: accumulate adds clamp to signed max/min.
module accum_bank
  import psum_accum_pkg::*;
#(
  parameter int PW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] psum,
  input  logic          acc_mode,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] old_v;
  logic [PW-1:0] sum_v;
  logic [PW-1:0] acc_v;
  logic [PW-1:0] wdata;

  // next value for the addressed entry
  always_comb begin
    old_v = mem[waddr];
    sum_v = old_v + psum;
`ifdef ACCUM_SAT_EN
    unique case (1'b1)
      sat_sel(old_v[PW-1], psum[PW-1], sum_v[PW-1])[1]:
        acc_v = {1'b0, {(PW-1){1'b1}}};
      sat_sel(old_v[PW-1], psum[PW-1], sum_v[PW-1])[0]:
        acc_v = {1'b1, {(PW-1){1'b0}}};
      default:
        acc_v = sum_v;
    endcase
`else
    acc_v = sum_v;
`endif
    wdata = acc_mode ? acc_v : psum;
  end

  // bank write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, returns pre-write data on a collision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[raddr];
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Collects skewed column psums into per-column accumulator banks.
// ACCUM_SAT_EN: saturating accumulate (see accum_bank).
module psum_accum_ctrl
  import psum_accum_pkg::*;
#(
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 1024
) (
  input logic              clk,
  input logic              rstn,
  psum_accum_ctrl_if.slave bus
);
  localparam int PW = psum_width(DATA_WIDTH);
  localparam int ADDR_WIDTH = $clog2(ACCUM_SIZE);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  mode_q;

  logic [DATA_WIDTH-1:0] cnt     [SYS_COL];
  logic [DATA_WIDTH-1:0] cnt_nxt [SYS_COL];
  logic [ADDR_WIDTH-1:0] waddr   [SYS_COL];
  logic [SYS_COL-1:0]    col_we;
  logic [SYS_COL-1:0]    col_drop;
  logic                  all_full;
  logic                  start_ok;

  logic [SYS_COL-1:0][PW-1:0] rd_q;

  assign start_ok = (state == IDLE) && bus.start;

  // per-column accept/drop, write address and completion lookahead
  always_comb begin
    all_full = 1'b1;
    for (int j = 0; j < SYS_COL; j++) begin
      col_we[j]   = (state == COLLECT) && bus.en_in[j]
                    && (cnt[j] < num_q);
      col_drop[j] = bus.en_in[j] && !col_we[j];
      cnt_nxt[j]  = cnt[j] + DATA_WIDTH'(col_we[j]);
      waddr[j]    = base_q + ADDR_WIDTH'(cnt[j]);
      if (cnt_nxt[j] != num_q) all_full = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = (bus.num_row == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (all_full) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.busy = (state == COLLECT);
    bus.done = (state == DONE);
  end

  // latch pass parameters on an accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_q  <= '0;
      base_q <= '0;
      mode_q <= 1'b0;
    end else if (start_ok) begin
      num_q  <= bus.num_row;
      base_q <= bus.base_addr;
      mode_q <= bus.acc_mode;
    end
  end

  // independent column counters absorb the array skew
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < SYS_COL; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < SYS_COL; j++) begin
        if (start_ok)       cnt[j] <= '0;
        else if (col_we[j]) cnt[j] <= cnt_nxt[j];
      end
    end
  end

  // sticky drop flag, cleared by an accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         bus.ovf_err <= 1'b0;
    else if (start_ok) bus.ovf_err <= |col_drop;
    else               bus.ovf_err <= bus.ovf_err | (|col_drop);
  end

  generate
    for (genvar j = 0; j < SYS_COL; j++) begin : g_col
      accum_bank #(
        .PW    (PW),
        .DEPTH (ACCUM_SIZE),
        .AW    (ADDR_WIDTH)
      ) u_bank (
        .clk      (clk),
        .rstn     (rstn),
        .we       (col_we[j]),
        .waddr    (waddr[j]),
        .psum     (bus.psum_in[j]),
        .acc_mode (mode_q),
        .rd_en    (bus.rd_en),
        .raddr    (bus.rd_addr),
        .rd_data  (rd_q[j])
      );
    end
  endgenerate

  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed self-checking bench for psum_accum_ctrl.
// Define ACCUM_SAT_EN for both bench and RTL to check saturation.
module tb_psum_accum_ctrl;
  localparam int SC = 4;
  localparam int DW = 16;
  localparam int AS = 1024;
  localparam int PW = 32;
  localparam int RW = SC * PW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  psum_accum_ctrl_if #(
    .SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(AS)
  ) bus ();

  psum_accum_ctrl #(
    .SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(AS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] rq [$];
  logic [RW-1:0] exp_row;
  logic [RW-1:0] got;
  logic          seen_done;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [RW-1:0] obs,
                     input logic [RW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] row(input logic [31:0] v0,
                                        input logic [31:0] v1,
                                        input logic [31:0] v2,
                                        input logic [31:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  task automatic do_start(input int n, input int b, input bit m);
    bus.start     = 1'b1;
    bus.num_row   = DW'(n);
    bus.base_addr = 10'(b);
    bus.acc_mode  = m;
    tick();
    bus.start = 1'b0;
  endtask

  // expected value goes in the queue when the read is issued
  task automatic read_row(input string tag, input int a,
                          input logic [RW-1:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 10'(a);
    rq.push_back(exp);
    tick();
    bus.rd_en = 1'b0;
    chk(tag, bus.rd_data, rq.pop_front());
  endtask

  // column j gets off+10j+k at cycle k+j; optional 5th col-0 valid
  task automatic feed(input int off, input bit extra, input string tag);
    for (int t = 0; t < 7; t++) begin
      bus.en_in = '0;
      for (int j = 0; j < SC; j++) begin
        if (t - j >= 0 && t - j < 4) begin
          bus.en_in[j]   = 1'b1;
          bus.psum_in[j] = 32'(off + 10 * j + (t - j));
        end
      end
      if (extra && t == 4) begin
        bus.en_in[0]   = 1'b1;
        bus.psum_in[0] = 32'd555;
      end
      tick();
      if (t == 5) chk({tag, "_busy_nodone"},
                      RW'({bus.busy, bus.done}), RW'(2'b10));
    end
    bus.en_in = '0;
    chk({tag, "_done"}, RW'(bus.done), RW'(1));
    tick();
    chk({tag, "_after"}, RW'({bus.busy, bus.done}), RW'(2'b00));
  endtask

  initial begin
    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.num_row   = '0;
    bus.base_addr = '0;
    bus.acc_mode  = 1'b0;
    bus.psum_in   = '0;
    bus.en_in     = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(negedge clk);
    chk("reset_flags", RW'({bus.busy, bus.done, bus.ovf_err}), '0);
    chk("reset_rd", bus.rd_data, '0);
    rstn = 1'b1;
    tick();

    // overwrite pass
    do_start(4, 0, 0);
    chk("t1_busy", RW'(bus.busy), RW'(1));
    feed(0, 1'b0, "t1");
    read_row("t1_a2", 2, row(2, 12, 22, 32));
    read_row("t1_a0", 0, row(0, 10, 20, 30));

    // accumulate pass
    do_start(4, 0, 1);
    feed(0, 1'b0, "t2");
    read_row("t2_a2", 2, row(4, 24, 44, 64));
    read_row("t2_a3", 3, row(6, 26, 46, 66));
    chk("t2_ovf", RW'(bus.ovf_err), RW'(0));

    // address wrap
    do_start(4, 1022, 0);
    feed(100, 1'b0, "t3");
    read_row("t3_a1022", 1022, row(100, 110, 120, 130));
    read_row("t3_a1023", 1023, row(101, 111, 121, 131));
    read_row("t3_a0", 0, row(102, 112, 122, 132));
    read_row("t3_a1", 1, row(103, 113, 123, 133));
    chk("t3_ovf", RW'(bus.ovf_err), RW'(0));

    // drop while idle, then drop after column 0 finishes
    bus.en_in      = 4'b0001;
    bus.psum_in[0] = 32'd999;
    tick();
    bus.en_in = '0;
    chk("t4_idle_ovf", RW'(bus.ovf_err), RW'(1));
    read_row("t4_idle_a0", 0, row(102, 112, 122, 132));
    do_start(4, 0, 0);
    chk("t4_clear", RW'(bus.ovf_err), RW'(0));
    feed(0, 1'b1, "t4");
    chk("t4_late_ovf", RW'(bus.ovf_err), RW'(1));
    read_row("t4_a0", 0, row(0, 10, 20, 30));
    read_row("t4_a3", 3, row(3, 13, 23, 33));
    chk("t4_sticky", RW'(bus.ovf_err), RW'(1));

    // signed overflow on accumulate
    do_start(1, 5, 0);
    chk("t5_clear", RW'(bus.ovf_err), RW'(0));
    bus.psum_in = row(32'h7FFF_FFF0, 32'h8000_0010,
                      32'h7FFF_FFF0, 32'h8000_0010);
    bus.en_in = '1;
    tick();
    bus.en_in = '0;
    chk("t5_done0", RW'(bus.done), RW'(1));
    tick();
    do_start(1, 5, 1);
    bus.psum_in = row(32'h20, 32'hFFFF_FFE0, 32'h20, 32'hFFFF_FFE0);
    bus.en_in = '1;
    tick();
    bus.en_in = '0;
    chk("t5_done1", RW'(bus.done), RW'(1));
`ifdef ACCUM_SAT_EN
    exp_row = row(32'h7FFF_FFFF, 32'h8000_0000,
                  32'h7FFF_FFFF, 32'h8000_0000);
`else
    exp_row = row(32'h8000_0010, 32'h7FFF_FFF0,
                  32'h8000_0010, 32'h7FFF_FFF0);
`endif
    read_row("t5_a5", 5, exp_row);

    // zero-length pass completes at once
    do_start(0, 0, 0);
    chk("zero_done", RW'({bus.busy, bus.done}), RW'(2'b01));
    tick();
    chk("zero_after", RW'(bus.done), RW'(0));

    // reset mid-pass
    do_start(4, 8, 0);
    bus.psum_in = row(7, 7, 7, 7);
    bus.en_in = '1;
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    chk("t6_rst_flags", RW'({bus.busy, bus.done, bus.ovf_err}), '0);
    chk("t6_rst_rd", bus.rd_data, '0);
    bus.en_in = '0;
    @(negedge clk);
    rstn = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    chk("t6_no_done", RW'(seen_done), RW'(0));

    // fresh pass; start during COLLECT must be ignored
    do_start(1, 9, 0);
    do_start(0, 20, 1);
    chk("t6_ign_busy", RW'({bus.busy, bus.done}), RW'(2'b10));
    bus.psum_in = row(41, 42, 43, 44);
    bus.en_in = '1;
    tick();
    bus.en_in = '0;
    chk("t6_done", RW'(bus.done), RW'(1));
    read_row("t6_a9", 9, row(41, 42, 43, 44));

    // read on the done cycle sees final data
    do_start(4, 16, 0);
    for (int t = 0; t < 7; t++) begin
      bus.en_in = '0;
      for (int j = 0; j < SC; j++) begin
        if (t - j >= 0 && t - j < 4) begin
          bus.en_in[j]   = 1'b1;
          bus.psum_in[j] = 32'(200 + 10 * j + (t - j));
        end
      end
      tick();
    end
    bus.en_in = '0;
    got = RW'(bus.done);
    chk("t7_done", got, RW'(1));
    read_row("t7_a19", 19, row(203, 213, 223, 233));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
